// File: rtl/rv32ima_boot_loader.sv
// Boot sequencer: holds the core in reset, streams a length-prefixed image
// from a byte interface into instruction memory, then releases core reset.
module rv32ima_boot_loader #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned RST_HOLD  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic              core_rst_o,
  output logic              boot_done_o,
  output logic              boot_err_o
);

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
  localparam int unsigned WIDX_W = ADDR_W + 1;
  localparam int unsigned XW1    = XLEN + 1;

  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(NBYTES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [XW1-1:0]    CAPACITY  = XW1'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [XLEN-1:0]     shift_q, shift_d;
  logic [XLEN-1:0]     n_q, n_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                ready_d, we_d, run_d, err_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [XLEN-1:0]     wdata_d;
  logic                take;
  logic [XLEN-1:0]     shift_nx;
  logic [WIDX_W-1:0]   widx_inc;

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    n_d      = n_q;
    widx_d   = widx_q;
    hold_d   = hold_q;
    we_d     = 1'b0;
    addr_d   = mem_addr_o;
    wdata_d  = mem_wdata_o;
    take     = byte_valid_i && byte_ready_o;
    // Little-endian assembly: each new byte enters at the top and shifts down
    shift_nx = (shift_q >> 8) | (XLEN'(byte_data_i) << (XLEN - 8));
    widx_inc = widx_q + WIDX_W'(1);

    case (state_q)
      S_IDLE: begin
        state_d = S_HDR;
        bcnt_d  = '0;
        shift_d = '0;
        n_d     = '0;
        widx_d  = '0;
      end
      S_HDR: begin
        if (take) begin
          shift_d = shift_nx;
          bcnt_d  = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_LAST) begin
            n_d     = shift_nx;
            bcnt_d  = '0;
            shift_d = '0;
            hold_d  = '0;
            if (shift_nx == '0) begin
              state_d = S_HOLD;
            end else if ({1'b0, shift_nx} > CAPACITY) begin
              state_d = S_ERR;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
        if (take) begin
          shift_d = shift_nx;
          bcnt_d  = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_LAST) begin
            bcnt_d  = '0;
            shift_d = '0;
            we_d    = 1'b1;
            addr_d  = BASE + widx_q[ADDR_W-1:0];
            wdata_d = shift_nx;
            widx_d  = widx_inc;
            if (XW1'(widx_inc) == {1'b0, n_q}) begin
              state_d = S_HOLD;
              hold_d  = '0;
            end
          end
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_RUN, S_ERR: begin
        if (start_i) begin
          state_d = S_HDR;
          bcnt_d  = '0;
          shift_d = '0;
          n_d     = '0;
          widx_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_HDR) || (state_d == S_LOAD);
    run_d   = (state_d == S_RUN);
    err_d   = (state_d == S_ERR);
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      bcnt_q       <= '0;
      shift_q      <= '0;
      n_q          <= '0;
      widx_q       <= '0;
      hold_q       <= '0;
      byte_ready_o <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      core_rst_o   <= 1'b0;
      boot_done_o  <= 1'b0;
      boot_err_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      n_q          <= n_d;
      widx_q       <= widx_d;
      hold_q       <= hold_d;
      byte_ready_o <= ready_d;
      mem_we_o     <= we_d;
      mem_addr_o   <= addr_d;
      mem_wdata_o  <= wdata_d;
      core_rst_o   <= run_d;
      boot_done_o  <= run_d;
      boot_err_o   <= err_d;
    end
  end

endmodule

// File: tb/tb_rv32ima_boot_loader.sv
// Bench for rv32ima_boot_loader: two instances (base 0 and base 14) share one
// byte stream; writes are logged and compared with an image-level model.
module tb_rv32ima_boot_loader;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned RST_HOLD = 4;
  localparam int unsigned BASE0    = 0;
  localparam int unsigned BASE1    = 14;
  localparam int unsigned DEPTH    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, valid;
  logic [7:0]  data;

  logic              ready0, we0, crst0, done0, err0;
  logic [ADDR_W-1:0] addr0;
  logic [XLEN-1:0]   wdata0;
  logic              ready1, we1, crst1, done1, err1;
  logic [ADDR_W-1:0] addr1;
  logic [XLEN-1:0]   wdata1;

  rv32ima_boot_loader #(.XLEN(XLEN), .ADDR_W(ADDR_W), .BASE_ADDR(BASE0), .RST_HOLD(RST_HOLD)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .byte_valid_i(valid), .byte_data_i(data),
    .byte_ready_o(ready0), .mem_we_o(we0), .mem_addr_o(addr0), .mem_wdata_o(wdata0),
    .core_rst_o(crst0), .boot_done_o(done0), .boot_err_o(err0));

  rv32ima_boot_loader #(.XLEN(XLEN), .ADDR_W(ADDR_W), .BASE_ADDR(BASE1), .RST_HOLD(RST_HOLD)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .byte_valid_i(valid), .byte_data_i(data),
    .byte_ready_o(ready1), .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wdata1),
    .core_rst_o(crst1), .boot_done_o(done1), .boot_err_o(err1));

  // Edge counter: after edge e has happened, cyc == e
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write logs
  int unsigned wa0[$], wa1[$], wt0[$], wt1[$];
  logic [31:0] wd0[$], wd1[$];
  int unsigned long_cnt = 0;
  logic pw0 = 1'b0, pw1 = 1'b0;

  always @(negedge clk) begin
    if (we0) begin wa0.push_back(32'(addr0)); wd0.push_back(wdata0); wt0.push_back(cyc); end
    if (we1) begin wa1.push_back(32'(addr1)); wd1.push_back(wdata1); wt1.push_back(cyc); end
    if ((we0 && pw0) || (we1 && pw1)) long_cnt++;
    pw0 = we0;
    pw1 = we1;
  end

  // Reference model: image words and the edge each word's last byte was taken
  logic [31:0] img[$];
  int unsigned exp_edge[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned stall_pct, input bit rnd_start);
    int g;
    while (stall_pct != 0 && $urandom_range(99) < stall_pct) begin
      valid = 1'b0;
      if (rnd_start) start = 1'($urandom_range(1));
      step();
    end
    valid = 1'b1;
    data  = b;
    if (rnd_start) start = 1'($urandom_range(1));
    g = 0;
    while (!ready0 && g < 64) begin
      step();
      g++;
    end
    if (!ready0) begin
      chk("ready_timeout", 64'(ready0), 64'(1));
      valid = 1'b0;
      start = 1'b0;
      return;
    end
    step();
    valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned stall_pct, input bit rnd_start);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], stall_pct, rnd_start);
  endtask

  task automatic load_image(input logic [31:0] n, input int unsigned stall_pct, input bit rnd_start);
    send_word(n, stall_pct, rnd_start);
    if (n != 0 && n <= DEPTH) begin
      for (int i = 0; i < img.size(); i++) begin
        send_word(img[i], stall_pct, rnd_start);
        exp_edge.push_back(cyc);
      end
    end
    start = 1'b0;
  endtask

  task automatic check_release(input string tag);
    chk({tag, "_hold_crst0"}, 64'({crst0, done0, crst1, done1}), 64'(0));
    for (int i = 1; i < RST_HOLD; i++) begin
      step();
      chk({tag, "_hold_crst"}, 64'({crst0, done0, crst1, done1}), 64'(0));
    end
    step();
    chk({tag, "_release"}, 64'({crst0, done0, crst1, done1}), 64'hF);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wcnt0"}, 64'(wa0.size()), 64'(exp_edge.size()));
    chk({tag, "_wcnt1"}, 64'(wa1.size()), 64'(exp_edge.size()));
    for (int i = 0; i < exp_edge.size(); i++) begin
      if (i < wa0.size()) begin
        chk({tag, "_addr0"}, 64'(wa0[i]), 64'((BASE0 + i) % DEPTH));
        chk({tag, "_data0"}, 64'(wd0[i]), 64'(img[i]));
        chk({tag, "_edge0"}, 64'(wt0[i]), 64'(exp_edge[i]));
      end
      if (i < wa1.size()) begin
        chk({tag, "_addr1"}, 64'(wa1[i]), 64'((BASE1 + i) % DEPTH));
        chk({tag, "_data1"}, 64'(wd1[i]), 64'(img[i]));
      end
    end
    chk({tag, "_strobe_len"}, 64'(long_cnt), 64'(0));
    wa0.delete(); wa1.delete(); wd0.delete(); wd1.delete(); wt0.delete(); wt1.delete();
    exp_edge.delete();
  endtask

  task automatic reboot(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_reboot0"}, 64'({crst0, done0, ready0}), 64'(1));
    chk({tag, "_reboot1"}, 64'({crst1, done1, ready1}), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs0"}, 64'({ready0, we0, addr0, wdata0, crst0, done0, err0}), 64'(0));
    chk({tag, "_outs1"}, 64'({ready1, we1, addr1, wdata1, crst1, done1, err1}), 64'(0));
  endtask

  task automatic set_basic();
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'h0010_0093);
  endtask

  task automatic set_random(input int unsigned n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  initial begin
    int unsigned n;
    rst = 1'b0; start = 1'b0; valid = 1'b0; data = 8'h00;

    // Reset state and release timing
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    chk("idle_ready", 64'({ready0, ready1}), 64'(0));
    step();
    chk("hdr_ready", 64'({ready0, ready1}), 64'(3));

    // Basic load
    set_basic();
    load_image(32'd2, 0, 1'b0);
    check_release("basic");
    check_writes("basic");
    reboot("basic");

    // Empty image
    img.delete();
    load_image(32'd0, 0, 1'b0);
    check_release("empty");
    check_writes("empty");
    reboot("empty");

    // Oversize image
    img.delete();
    load_image(32'd17, 0, 1'b0);
    chk("over_err0", 64'({err0, ready0, crst0}), 64'(4));
    chk("over_err1", 64'({err1, ready1, crst1}), 64'(4));
    valid = 1'b1; data = 8'hA5;
    repeat (3) step();
    valid = 1'b0;
    chk("over_stay", 64'({err0, ready0, crst0, err1}), 64'(9));
    check_writes("over");
    start = 1'b1;
    step();
    start = 1'b0;
    chk("over_restart", 64'({err0, ready0, err1, ready1}), 64'(5));
    set_basic();
    load_image(32'd2, 0, 1'b0);
    check_release("over_reload");
    check_writes("over_reload");
    reboot("over_reload");

    // Stalled stream with ignored start pulses
    set_basic();
    load_image(32'd2, 40, 1'b1);
    check_release("stall");
    check_writes("stall");
    reboot("stall");

    // Random image length and contents, stalled
    n = $urandom_range(16, 1);
    set_random(n);
    load_image(32'(n), 30, 1'b1);
    check_release("random");
    check_writes("random");
    reboot("random");

    // Reset mid-load, after 2 bytes of the second word
    set_basic();
    send_word(32'd2, 0, 1'b0);
    send_word(img[0], 0, 1'b0);
    exp_edge.push_back(cyc);
    send_byte(img[1][7:0], 0, 1'b0);
    send_byte(img[1][15:8], 0, 1'b0);
    rst = 1'b0;
    step();
    check_reset_outputs("midrst");
    rst = 1'b1;
    chk("midrst_idle", 64'({ready0, ready1}), 64'(0));
    step();
    chk("midrst_hdr", 64'({ready0, ready1}), 64'(3));
    repeat (2) step();
    check_writes("midrst");
    set_basic();
    load_image(32'd2, 0, 1'b0);
    check_release("midrst_reload");
    check_writes("midrst_reload");
    reboot("midrst_reload");

    // Full capacity then reboot and wrapping reload
    set_random(16);
    load_image(32'd16, 0, 1'b0);
    check_release("full");
    check_writes("full");
    reboot("full");
    set_random(3);
    load_image(32'd3, 0, 1'b0);
    check_release("wrap");
    check_writes("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32ima_boot_loader.md
# rv32ima_boot_loader

Parametrised boot sequencer that sits between an external byte stream (debug/UART bridge) and the SoC instruction memory. It holds the core in reset, receives a length-prefixed program image, writes it word-by-word into instruction memory, then releases core reset after a programmable hold period. It replaces loading the program image through simulation-only memory initialisation with a synthesizable, re-triggerable load-and-release path usable in silicon and in the top-level bench.

## Interface
Parameters:
- XLEN, 32: word width in bits; must be a multiple of 8.
- ADDR_W, 10: instruction-memory word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0: first word address written; addresses wrap modulo 2^ADDR_W.
- RST_HOLD, 16: cycles core reset stays asserted after the last write; must be ≥1.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-low.
- start_i  in  1  reboot request pulse; honoured only in RUN or ERR.
- byte_valid_i  in  1  byte_data_i is valid.
- byte_data_i  in  8  image byte.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- mem_we_o  out  1  one-cycle instruction-memory write strobe.
- mem_addr_o  out  ADDR_W  word write address.
- mem_wdata_o  out  XLEN  write data.
- core_rst_o  out  1  core reset, active-low (0 = core held).
- boot_done_o  out  1  image loaded, core running.
- boot_err_o  out  1  image rejected.

## Operation
- Byte transfer occurs on a rising edge where byte_valid_i && byte_ready_o. byte_ready_o = 1 only in HDR and LOAD.
- Image format: XLEN/8 header bytes giving word count N (little-endian), then N words, each XLEN/8 bytes little-endian.
- States:
  - IDLE: entered on reset. Moves to HDR unconditionally on the next edge.
  - HDR: assembles N. On the last header byte: N == 0 → HOLD; N > 2^ADDR_W → ERR; otherwise → LOAD.
  - LOAD: assembles bytes into a word. When a word completes, mem_we_o pulses for one cycle with mem_addr_o = BASE_ADDR + index (mod 2^ADDR_W). Index increments after each write. After word N completes → HOLD.
  - HOLD: counts RST_HOLD cycles with core_rst_o = 0, then → RUN.
  - RUN: core_rst_o = 1, boot_done_o = 1. start_i → HDR, clearing the index, the byte counter and N.
  - ERR: boot_err_o = 1, core_rst_o = 0, no further writes. start_i → HDR.
- start_i is ignored in IDLE, HDR, LOAD and HOLD.
- N is held at XLEN bits. The comparison against 2^ADDR_W is done at XLEN+1 bits, so there is no overflow.
- Stalls (byte_valid_i low) may occur anywhere, including mid-header and mid-word, with no effect on the result.

## Timing
- Reset values (rst_i sampled low at an edge): state IDLE; all outputs 0, including core_rst_o = 0; the partial word and counters are cleared.
- Mid-operation reset aborts immediately. Any partial word is discarded and no strobe is issued.
- After rst_i is released: one cycle in IDLE with byte_ready_o = 0, then byte_ready_o = 1.
- Write latency: if the final byte of a word is accepted at edge k, then mem_we_o, mem_addr_o and mem_wdata_o are registered at edge k. They are valid for exactly one cycle and drop at edge k+1.
- byte_ready_o stays 1 through the write cycle, so back-to-back words sustain 1 byte per cycle.
- mem_addr_o and mem_wdata_o hold their last values when mem_we_o = 0.
- HOLD length: if the last word completes at edge k (state = HOLD from edge k), core_rst_o and boot_done_o go 1 at edge k+RST_HOLD.
- Entry into HOLD does not wait for the write strobe to drop; the final write completes during the first HOLD cycle.
- start_i accepted in RUN at edge k: at that edge, core_rst_o = 0, boot_done_o = 0 and state = HDR.
- start_i accepted in ERR at edge k: at that edge, boot_err_o = 0 and state = HDR.
- Errors: on ERR entry at edge k, boot_err_o = 1 and byte_ready_o = 0 from edge k.

## Test plan
Bench parameters: XLEN=32, ADDR_W=4, BASE_ADDR=0, RST_HOLD=4.

- **Basic load.** Bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 streamed with no stalls → writes (addr 0, 0x00000013) then (addr 1, 0x00100093), each a 1-cycle strobe. core_rst_o and boot_done_o rise 4 cycles after the second write edge.
- **Empty image.** Header 00 00 00 00 → no mem_we_o pulse; RUN reached 4 cycles after the last header byte.
- **Oversize image.** Header 11 00 00 00 (17 > 16) → boot_err_o = 1, byte_ready_o = 0, core_rst_o = 0, no writes. A start_i pulse returns to HDR with boot_err_o = 0, and a valid image then loads correctly.
- **Stalled stream.** The basic-load image with byte_valid_i randomly deasserted (including mid-header and mid-word) → identical writes and data.
- **Reset mid-load.** rst_i low for 1 cycle after 2 bytes of the second word → all outputs 0, no second write. After release, one cycle with ready = 0, then a full resend loads correctly.
- **Reboot from RUN, full capacity.** After a 16-word image, start_i pulse → core_rst_o = 0 and boot_done_o = 0 at the next edge. Reloading with BASE_ADDR=14 and N=3 writes addresses 14, 15, 0 (wrap).
